// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO feeding a configurable UART serializer (5-8 data bits,
// optional even/odd parity, 1 or 2 stop bits). Frames are sent back-to-back while data is queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  output logic                          tx_line,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push, pop;
  logic [7:0]       head;

  // Readiness comes from the registered level only, so a pop in the same cycle never admits a write.
  assign tx_ready   = (level != LVL_FULL);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = level;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // ---------------------------------------------------------------- serializer
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       last_q, last_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d;
  logic             stop_q, stop_d;
  logic             line_q, line_d;
  logic [7:0]       data_mask;

  assign data_mask = 8'hFF >> (2'd3 - cfg_data_bits);
  assign tx_line   = line_q;
  assign tx_busy   = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      last_q    <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_q    <= 1'b0;
      line_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      stop_q    <= stop_d;
      line_q    <= line_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    last_d    = last_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    stop_d    = stop_q;
    line_d    = line_q;
    pop       = 1'b0;

    if (state_q == S_IDLE) begin
      line_d = 1'b1;
      cnt_d  = '0;
      pop    = (level != '0);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            bit_d   = '0;
            line_d  = shift_q[0];
          end
          S_DATA: begin
            if (bit_q == last_q) begin
              if (par_en_q) begin
                state_d = S_PARITY;
                line_d  = par_bit_q;
              end else begin
                state_d = S_STOP;
                stop_d  = 1'b0;
                line_d  = 1'b1;
              end
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = shift_q >> 1;
              line_d  = shift_q[1];
            end
          end
          S_PARITY: begin
            state_d = S_STOP;
            stop_d  = 1'b0;
            line_d  = 1'b1;
          end
          S_STOP: begin
            if (stop2_q && !stop_q) begin
              stop_d = 1'b1;
            end else if (level != '0) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              line_d  = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Starting a frame latches the configuration so mid-frame changes cannot disturb it.
    if (pop) begin
      state_d   = S_START;
      cnt_d     = '0;
      line_d    = 1'b0;
      shift_d   = head;
      last_d    = 3'd4 + {1'b0, cfg_data_bits};
      par_en_d  = cfg_parity_en;
      par_bit_d = (^(head & data_mask)) ^ cfg_parity_odd;
      stop2_d   = cfg_stop2;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BIT_CYC=16, FIFO_DEPTH=4: frame formats, queueing,
// back-to-back frames, config sampling and mid-frame reset.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rstn;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [1:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_stop2;
  logic       tx_line;
  logic       tx_busy;
  logic [2:0] fifo_level;

  int n_chk  = 0;
  int n_pass = 0;

  uart_tx_fifo #(
    .CLK_FREQ  (1600),
    .BAUD_RATE (100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity_en (cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2     (cfg_stop2),
    .tx_line       (tx_line),
    .tx_busy       (tx_busy),
    .fifo_level    (fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_line"}, tx_line, 1'b1);
      check({tag, "_busy"}, tx_busy, 1'b0);
      @(negedge clk);
    end
    check({tag, "_level"}, fifo_level, 3'd0);
  endtask

  // bits[k] is the line level of bit period k (start bit first); checks cycles [from, upto).
  task automatic frame(input string tag, input logic [11:0] bits, input int from, input int upto);
    for (int c = from; c < upto; c++) begin
      check({tag, "_line"}, tx_line, bits[c/16]);
      check({tag, "_busy"}, tx_busy, 1'b1);
      @(negedge clk);
    end
  endtask

  // Single write into an empty idle FIFO; returns at the first cycle of the start bit.
  task automatic write_then_start(input string tag, input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    check({tag, "_lvl_after_write"}, fifo_level, 3'd1);
    check({tag, "_line_after_write"}, tx_line, 1'b1);
    check({tag, "_busy_after_write"}, tx_busy, 1'b0);
    tx_valid = 1'b0;
    @(negedge clk);
    check({tag, "_start_line"}, tx_line, 1'b0);
    check({tag, "_start_busy"}, tx_busy, 1'b1);
    check({tag, "_start_level"}, fifo_level, 3'd0);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pe, input logic po, input logic s2);
    cfg_data_bits  = db;
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_stop2      = s2;
  endtask

  logic [7:0] burst [6];
  int         burst_lvl [6];
  logic       burst_rdy [6];

  initial begin
    rstn     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    burst     = '{8'hA1, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'hEE};
    burst_lvl = '{1, 1, 2, 3, 4, 4};
    burst_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state, and no spontaneous frame after release.
    repeat (2) @(negedge clk);
    check("rst_line", tx_line, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_level", fifo_level, 3'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_idle("post_rst", 3);

    // 8N1, 0x55.
    write_then_start("8n1", 8'h55);
    frame("8n1", {2'b00, 1'b1, 8'h55, 1'b0}, 0, 160);
    check_idle("8n1_end", 4);

    // 7E2, 0x83: bit 7 dropped, even parity of 0000011 is 0.
    set_cfg(2'd2, 1'b1, 1'b0, 1'b1);
    write_then_start("7e2", 8'h83);
    frame("7e2", {1'b0, 2'b11, 1'b0, 7'h03, 1'b0}, 0, 176);
    check_idle("7e2_end", 4);

    // 5O1, 0x1F: odd parity over five ones is 0.
    set_cfg(2'd0, 1'b1, 1'b1, 1'b0);
    write_then_start("5o1", 8'h1F);
    frame("5o1", {4'b0000, 1'b1, 1'b0, 5'h1F, 1'b0}, 0, 128);
    check_idle("5o1_end", 20);

    // Six back-to-back writes: first is popped, four queue, sixth dropped while full.
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1;
      tx_data  = burst[i];
      @(negedge clk);
      check($sformatf("burst_lvl%0d", i), fifo_level, burst_lvl[i]);
      check($sformatf("burst_rdy%0d", i), tx_ready, burst_rdy[i]);
    end
    tx_valid = 1'b0;
    frame("burst0", {2'b00, 1'b1, burst[0], 1'b0}, 4, 160);
    for (int k = 1; k < 5; k++) begin
      check($sformatf("burst%0d_level", k), fifo_level, 4 - k);
      frame($sformatf("burst%0d", k), {2'b00, 1'b1, burst[k], 1'b0}, 0, 160);
    end
    check_idle("burst_end", 20);

    // Config change mid-DATA only affects the following frame.
    tx_valid = 1'b1;
    tx_data  = 8'hC5;
    @(negedge clk);
    tx_data  = 8'h6A;
    @(negedge clk);
    tx_valid = 1'b0;
    check("cfg_q_level", fifo_level, 3'd1);
    frame("cfg_f1a", {2'b00, 1'b1, 8'hC5, 1'b0}, 0, 40);
    cfg_data_bits = 2'd0;
    frame("cfg_f1b", {2'b00, 1'b1, 8'hC5, 1'b0}, 40, 160);
    check("cfg_f2_level", fifo_level, 3'd0);
    frame("cfg_f2", {5'b00000, 1'b1, 5'h0A, 1'b0}, 0, 112);
    check_idle("cfg_end", 4);

    // Reset in the middle of frame 2's data with two bytes still queued.
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_data  = 8'h00;
    @(negedge clk);
    tx_data  = 8'h12;
    @(negedge clk);
    tx_data  = 8'h34;
    @(negedge clk);
    tx_valid = 1'b0;
    check("mid_q_level", fifo_level, 3'd3);
    repeat (158) @(negedge clk);
    check("mid_f2_start", tx_line, 1'b0);
    check("mid_f2_level", fifo_level, 3'd2);
    repeat (48) @(negedge clk);
    check("mid_f2_data", tx_line, 1'b0);
    check("mid_f2_busy", tx_busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("mid_rst_line", tx_line, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_level", fifo_level, 3'd0);
    check("mid_rst_ready", tx_ready, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_idle("mid_after", 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
